doa_pair_scheduler: RTL and testbench

//  Frame scheduler in front of the 2-input peak-lag compare datapath. Shares that datapath across
//  NUM_PAIR mic-pair correlation stream pairs: one enabled pair per frame, round-robin.

---
 rtl/doa_pair_scheduler_pkg.sv | 20 ++
 rtl/doa_pair_scheduler_if.sv | 29 ++
 rtl/doa_pair_scheduler_rr_pick.sv | 30 +++
 rtl/doa_pair_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_doa_pair_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/doa_pair_scheduler_pkg.sv
// Shared constants and FSM encoding for the DOA pair scheduler and its interface.
package doa_pair_scheduler_pkg;

    localparam int DOA_NUM_PAIR  = 4;
    localparam int DOA_DW        = 64;
    localparam int DOA_FRAME_LEN = 4096;
    localparam int DOA_TIMEOUT   = 256;
    localparam int RES_W         = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_STREAM,
        ST_WAIT,
        ST_STORE,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/doa_pair_scheduler_if.sv
// Stream-in and compare-datapath handshake bundle; master is the scheduler side.
interface doa_pair_scheduler_if #(
    parameter int NUM_PAIR = doa_pair_scheduler_pkg::DOA_NUM_PAIR,
    parameter int DW       = doa_pair_scheduler_pkg::DOA_DW
);
    import doa_pair_scheduler_pkg::*;

    logic [NUM_PAIR*2*DW-1:0] s_tdata;
    logic [NUM_PAIR*2-1:0]    s_tvalid;
    logic [NUM_PAIR*2-1:0]    s_tready;
    logic [DW-1:0]            m00_tdata;
    logic                     m00_tvalid;
    logic [DW-1:0]            m01_tdata;
    logic                     m01_tvalid;
    logic                     cmp_done;
    logic [RES_W-1:0]         cmp_result;
    logic                     cmp_ack;

    modport master (
        input  s_tdata, s_tvalid, cmp_done, cmp_result,
        output s_tready, m00_tdata, m00_tvalid, m01_tdata, m01_tvalid, cmp_ack
    );

    modport slave (
        output s_tdata, s_tvalid, cmp_done, cmp_result,
        input  s_tready, m00_tdata, m00_tvalid, m01_tdata, m01_tvalid, cmp_ack
    );

endinterface

// File: rtl/doa_pair_scheduler_rr_pick.sv
// Round-robin pick: first set mask bit at or after ptr, wrapping over NUM_PAIR.
module doa_pair_scheduler_rr_pick #(
    parameter int NUM_PAIR = 4,
    parameter int PW       = 2
) (
    input  logic [NUM_PAIR-1:0] mask,
    input  logic [PW-1:0]       ptr,
    output logic [PW-1:0]       pick,
    output logic                found
);

    logic [PW:0] idx;

    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PAIR; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_PAIR)) begin
                idx = idx - (PW+1)'(NUM_PAIR);
            end
            if (!found && mask[idx[PW-1:0]]) begin
                pick  = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/doa_pair_scheduler.sv
// Time-shares one peak-lag compare datapath across NUM_PAIR stream pairs, one frame per pair,
// banking each 6-bit lag result and raising an IRQ per sweep.
module doa_pair_scheduler
    import doa_pair_scheduler_pkg::*;
#(
    parameter int NUM_PAIR  = DOA_NUM_PAIR,
    parameter int DW        = DOA_DW,
    parameter int FRAME_LEN = DOA_FRAME_LEN,
    parameter int TIMEOUT   = DOA_TIMEOUT,
    parameter int PW        = $clog2(NUM_PAIR)
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic                      ctrl_start,
    input  logic                      ctrl_continuous,
    input  logic [NUM_PAIR-1:0]       ctrl_pair_mask,
    doa_pair_scheduler_if.master      bus,
    output logic [NUM_PAIR*RES_W-1:0] res_bank,
    output logic [NUM_PAIR-1:0]       res_valid,
    output logic [NUM_PAIR-1:0]       res_err,
    output logic [PW-1:0]             cur_pair,
    output logic                      busy,
    output logic                      sweep_irq,
    input  logic                      sweep_irq_ack
);

    localparam int BW = $clog2(FRAME_LEN);
    localparam int TW = $clog2(TIMEOUT);

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       pick;
    logic                pick_found;
    logic [NUM_PAIR-1:0] pending;
    logic [NUM_PAIR-1:0] pending_left;
    logic [NUM_PAIR-1:0] mask_lat;
    logic [BW-1:0]       beat_cnt;
    logic [TW-1:0]       to_cnt;
    logic [2*DW-1:0]     pair_data;
    logic                joint;
    logic [2*NUM_PAIR-1:0] ready_vec;
    logic [DW-1:0]       m00_data_q;
    logic [DW-1:0]       m01_data_q;
    logic                m_valid_q;
    logic                cmp_ack_q;

    doa_pair_scheduler_rr_pick #(
        .NUM_PAIR (NUM_PAIR),
        .PW       (PW)
    ) u_rr_pick (
        .mask  (pending),
        .ptr   (ptr),
        .pick  (pick),
        .found (pick_found)
    );

    // Join the a/b streams of the serviced pair; only that pair ever sees ready.
    always_comb begin
        pair_data = '0;
        joint     = 1'b0;
        ready_vec = '0;
        for (int p = 0; p < NUM_PAIR; p++) begin
            if (cur_pair == PW'(p)) begin
                pair_data = bus.s_tdata[p*2*DW +: 2*DW];
                joint     = bus.s_tvalid[2*p] && bus.s_tvalid[2*p+1];
                ready_vec[2*p +: 2] = {2{(state == ST_STREAM) && joint}};
            end
        end
        pending_left = pending & ~(NUM_PAIR'(1) << cur_pair);
    end

    assign bus.s_tready   = ready_vec;
    assign bus.m00_tdata  = m00_data_q;
    assign bus.m01_tdata  = m01_data_q;
    assign bus.m00_tvalid = m_valid_q;
    assign bus.m01_tvalid = m_valid_q;
    assign bus.cmp_ack    = cmp_ack_q;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            pending    <= '0;
            mask_lat   <= '0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
            m00_data_q <= '0;
            m01_data_q <= '0;
            m_valid_q  <= 1'b0;
            cmp_ack_q  <= 1'b0;
            res_bank   <= '0;
            res_valid  <= '0;
            res_err    <= '0;
            cur_pair   <= '0;
            busy       <= 1'b0;
            sweep_irq  <= 1'b0;
        end else begin
            cmp_ack_q <= 1'b0;
            m_valid_q <= 1'b0;
            // The DONE-state set below overrides this clear when both land together.
            if (sweep_irq_ack) begin
                sweep_irq <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (ctrl_start && (ctrl_pair_mask != '0)) begin
                        mask_lat  <= ctrl_pair_mask;
                        pending   <= ctrl_pair_mask;
                        ptr       <= '0;
                        res_valid <= '0;
                        res_err   <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    cur_pair <= pick;
                    beat_cnt <= '0;
                    state    <= pick_found ? ST_STREAM : ST_DONE;
                end
                ST_STREAM: begin
                    if (joint) begin
                        m_valid_q  <= 1'b1;
                        m00_data_q <= pair_data[DW-1:0];
                        m01_data_q <= pair_data[2*DW-1:DW];
                        if (beat_cnt == BW'(FRAME_LEN-1)) begin
                            to_cnt <= '0;
                            state  <= ST_WAIT;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.cmp_done) begin
                        state <= ST_STORE;
                    end else if (to_cnt == TW'(TIMEOUT-1)) begin
                        res_err[cur_pair] <= 1'b1;
                        state             <= ST_NEXT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_STORE: begin
                    for (int p = 0; p < NUM_PAIR; p++) begin
                        if (cur_pair == PW'(p)) begin
                            res_bank[p*RES_W +: RES_W] <= bus.cmp_result;
                        end
                    end
                    res_valid[cur_pair] <= 1'b1;
                    cmp_ack_q           <= 1'b1;
                    state               <= ST_NEXT;
                end
                ST_NEXT: begin
                    pending <= pending_left;
                    if (pending_left == '0) begin
                        state <= ST_DONE;
                    end else begin
                        ptr   <= (cur_pair == PW'(NUM_PAIR-1)) ? '0 : cur_pair + PW'(1);
                        state <= ST_SEL;
                    end
                end
                ST_DONE: begin
                    sweep_irq <= 1'b1;
                    if (ctrl_continuous) begin
                        pending   <= mask_lat;
                        res_valid <= '0;
                        res_err   <= '0;
                        state     <= ST_SEL;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_doa_pair_scheduler.sv
// Directed bench for doa_pair_scheduler with a behavioural compare-datapath model.
module tb_doa_pair_scheduler;

    localparam int NP  = 4;
    localparam int DWL = 64;
    localparam int FL  = 4096;

    logic        axis_aclk = 1'b0;
    logic        axis_aresetn = 1'b0;
    logic        ctrl_start = 1'b0;
    logic        ctrl_continuous = 1'b0;
    logic [3:0]  ctrl_pair_mask = 4'h0;
    logic        sweep_irq_ack = 1'b0;
    logic [23:0] res_bank;
    logic [3:0]  res_valid;
    logic [3:0]  res_err;
    logic [1:0]  cur_pair;
    logic        busy;
    logic        sweep_irq;

    logic [7:0]  valid_base = 8'h00;
    logic [7:0]  toggle_mask = 8'h00;
    logic        toggle_phase = 1'b0;
    logic [7:0]  allowed_ready = 8'hFF;
    logic [3:0]  no_done_mask = 4'h0;
    logic [5:0]  res_tab [NP];
    logic        cmp_done_r = 1'b0;
    logic [5:0]  cmp_res_r = 6'h0;

    int tests = 0;
    int failures = 0;
    int total_beats = 0;
    int beat_seen = 0;
    int served_cnt = 0;
    logic [15:0] served_log = 16'h0;
    int ack_cnt = 0;
    int rdy_bad = 0;
    int tv_bad = 0;
    int data_bad = 0;
    int irq_rises = 0;
    logic prev_hs = 1'b0;
    logic prev_irq = 1'b0;

    doa_pair_scheduler_if #(.NUM_PAIR(NP), .DW(DWL)) bus ();

    doa_pair_scheduler dut (
        .axis_aclk       (axis_aclk),
        .axis_aresetn    (axis_aresetn),
        .ctrl_start      (ctrl_start),
        .ctrl_continuous (ctrl_continuous),
        .ctrl_pair_mask  (ctrl_pair_mask),
        .bus             (bus),
        .res_bank        (res_bank),
        .res_valid       (res_valid),
        .res_err         (res_err),
        .cur_pair        (cur_pair),
        .busy            (busy),
        .sweep_irq       (sweep_irq),
        .sweep_irq_ack   (sweep_irq_ack)
    );

    always #5 axis_aclk = ~axis_aclk;

    assign bus.s_tvalid   = valid_base & ~(toggle_phase ? toggle_mask : 8'h00);
    assign bus.cmp_done   = cmp_done_r;
    assign bus.cmp_result = cmp_res_r;

    function automatic logic [63:0] stream_pat(input int k);
        return {8'(k), 56'h5A5A0000123456};
    endfunction

    // Flips the toggled stream valids shortly after each rising edge.
    always @(posedge axis_aclk) begin
        #2;
        if (!axis_aresetn) toggle_phase = 1'b0;
        else if (toggle_mask != 8'h00) toggle_phase = ~toggle_phase;
    end

    // Compare-datapath model and protocol monitor, evaluated on the falling edge.
    always @(negedge axis_aclk) begin
        if (!axis_aresetn) begin
            beat_seen  = 0;
            cmp_done_r = 1'b0;
            prev_hs    = 1'b0;
            prev_irq   = 1'b0;
        end else begin
            if (bus.cmp_ack) begin
                ack_cnt++;
                cmp_done_r = 1'b0;
            end
            if (bus.m00_tvalid !== prev_hs) tv_bad++;
            if (bus.m00_tvalid !== bus.m01_tvalid) tv_bad++;
            if (bus.m00_tvalid) begin
                total_beats++;
                if (bus.m00_tdata !== stream_pat(2*int'(cur_pair)) ||
                    bus.m01_tdata !== stream_pat(2*int'(cur_pair)+1)) data_bad++;
                beat_seen++;
                if (beat_seen == FL) begin
                    beat_seen = 0;
                    served_cnt++;
                    served_log = {served_log[11:0], 2'b00, cur_pair};
                    if (!no_done_mask[cur_pair]) begin
                        cmp_done_r = 1'b1;
                        cmp_res_r  = res_tab[cur_pair];
                    end
                end
            end
            if ((bus.s_tready & ~allowed_ready) != 8'h00) rdy_bad++;
            if ((bus.s_tready & ~bus.s_tvalid) != 8'h00) tv_bad++;
            prev_hs = |(bus.s_tready & bus.s_tvalid);
            if (sweep_irq && !prev_irq) irq_rises++;
            prev_irq = sweep_irq;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] mask, input logic cont);
        @(negedge axis_aclk);
        ctrl_pair_mask  = mask;
        ctrl_continuous = cont;
        ctrl_start      = 1'b1;
        @(negedge axis_aclk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles, output int cycles);
        cycles = 0;
        while (busy !== 1'b0 && cycles < max_cycles) begin
            @(negedge axis_aclk);
            cycles++;
        end
        check_output(tag, {63'b0, busy}, 64'h0);
        @(negedge axis_aclk);
    endtask

    task automatic wait_irq(input string tag, input int max_cycles);
        int cycles = 0;
        while (sweep_irq !== 1'b1 && cycles < max_cycles) begin
            @(negedge axis_aclk);
            cycles++;
        end
        check_output(tag, {63'b0, sweep_irq}, 64'h1);
        @(negedge axis_aclk);
    endtask

    task automatic ack_irq(input string tag);
        @(negedge axis_aclk);
        sweep_irq_ack = 1'b1;
        @(negedge axis_aclk);
        sweep_irq_ack = 1'b0;
        check_output(tag, {63'b0, sweep_irq}, 64'h0);
    endtask

    initial begin
        int cyc;
        int beats0, acks0, served0, rdy0, tv0, data0, irq0;

        for (int k = 0; k < 2*NP; k++) bus.s_tdata[k*64 +: 64] = stream_pat(k);
        res_tab[0] = 6'o12;
        res_tab[1] = 6'o27;
        res_tab[2] = 6'o41;
        res_tab[3] = 6'o35;

        repeat (3) @(negedge axis_aclk);
        check_output("rst_ctrl", {59'b0, busy, sweep_irq, bus.cmp_ack, bus.m00_tvalid, bus.m01_tvalid}, 64'h0);
        check_output("rst_ready", {56'b0, bus.s_tready}, 64'h0);
        check_output("rst_res", {54'b0, res_valid, res_err, cur_pair}, 64'h0);
        check_output("rst_bank", {40'b0, res_bank}, 64'h0);
        axis_aresetn = 1'b1;
        valid_base   = 8'hFF;

        // Empty mask start is not accepted.
        apply_stimulus(4'h0, 1'b0);
        @(negedge axis_aclk);
        check_output("zero_mask_idle", {62'b0, busy, sweep_irq}, 64'h0);

        // Sweep A: all pairs, all streams valid; a mid-sweep start is ignored.
        beats0 = total_beats; acks0 = ack_cnt; served0 = served_cnt; irq0 = irq_rises;
        tv0 = tv_bad; data0 = data_bad;
        apply_stimulus(4'hF, 1'b0);
        repeat (100) @(negedge axis_aclk);
        ctrl_pair_mask = 4'h1;
        ctrl_start     = 1'b1;
        @(negedge axis_aclk);
        ctrl_start = 1'b0;
        wait_idle("A_done_timeout", 20000, cyc);
        check_output("A_order", {48'b0, served_log}, 64'h0123);
        check_output("A_served", served_cnt - served0, 4);
        check_output("A_beats", total_beats - beats0, 4*FL);
        check_output("A_res_valid", {60'b0, res_valid}, 64'hF);
        check_output("A_res_err", {60'b0, res_err}, 64'h0);
        check_output("A_bank", {40'b0, res_bank}, {40'b0, 6'o35, 6'o41, 6'o27, 6'o12});
        check_output("A_bank_pair3", {58'b0, res_bank[23:18]}, {58'b0, 6'o35});
        check_output("A_acks", ack_cnt - acks0, 4);
        check_output("A_irq_rises", irq_rises - irq0, 1);
        check_output("A_irq_level", {63'b0, sweep_irq}, 64'h1);
        check_output("A_handshake", tv_bad - tv0, 0);
        check_output("A_data", data_bad - data0, 0);
        ack_irq("A_irq_ack");

        // Sweep B: pairs 0 and 2 only; pair 1 bank entry must be held.
        res_tab[0]    = 6'o55;
        allowed_ready = 8'b0011_0011;
        beats0 = total_beats; served0 = served_cnt; rdy0 = rdy_bad;
        apply_stimulus(4'b0101, 1'b0);
        wait_idle("B_done_timeout", 12000, cyc);
        check_output("B_order", {56'b0, served_log[7:0]}, 64'h02);
        check_output("B_beats", total_beats - beats0, 2*FL);
        check_output("B_res_valid", {60'b0, res_valid}, 64'h5);
        check_output("B_ready_idle_pairs", rdy_bad - rdy0, 0);
        check_output("B_bank", {40'b0, res_bank}, {40'b0, 6'o35, 6'o41, 6'o27, 6'o55});
        ack_irq("B_irq_ack");

        // Sweep C: pair 1 stream b valid only every other cycle.
        res_tab[1]    = 6'o63;
        allowed_ready = 8'b0000_1100;
        toggle_mask   = 8'b0000_1000;
        beats0 = total_beats; tv0 = tv_bad; rdy0 = rdy_bad; data0 = data_bad;
        apply_stimulus(4'b0010, 1'b0);
        wait_idle("C_done_timeout", 12000, cyc);
        check_output("C_beats", total_beats - beats0, FL);
        check_output("C_slow_join", {63'b0, (cyc > 8190)}, 64'h1);
        check_output("C_joint_only", tv_bad - tv0, 0);
        check_output("C_ready", rdy_bad - rdy0, 0);
        check_output("C_data", data_bad - data0, 0);
        check_output("C_bank_pair1", {58'b0, res_bank[11:6]}, {58'b0, 6'o63});
        toggle_mask = 8'h00;
        ack_irq("C_irq_ack");

        // Sweep D: pair 2 never completes and must time out without stalling the sweep.
        no_done_mask  = 4'b0100;
        allowed_ready = 8'b0011_1100;
        acks0 = ack_cnt; irq0 = irq_rises;
        apply_stimulus(4'b0110, 1'b0);
        wait_idle("D_done_timeout", 12000, cyc);
        check_output("D_order", {56'b0, served_log[7:0]}, 64'h12);
        check_output("D_res_err", {60'b0, res_err}, 64'h4);
        check_output("D_res_valid", {60'b0, res_valid}, 64'h2);
        check_output("D_bank_pair2_held", {58'b0, res_bank[17:12]}, {58'b0, 6'o41});
        check_output("D_acks", ack_cnt - acks0, 1);
        check_output("D_irq", {63'b0, sweep_irq}, 64'h1);
        check_output("D_irq_rises", irq_rises - irq0, 1);
        no_done_mask = 4'h0;
        ack_irq("D_irq_ack");

        // Sweep E: continuous mode, then an async reset mid-stream and a fresh start.
        allowed_ready = 8'hFF;
        apply_stimulus(4'b0011, 1'b1);
        wait_irq("E_irq_timeout", 12000);
        check_output("E_cont_busy", {63'b0, busy}, 64'h1);
        check_output("E_cont_res_clear", {56'b0, res_valid, res_err}, 64'h0);
        ack_irq("E_irq_ack");
        repeat (600) @(negedge axis_aclk);
        check_output("E_midstream_busy", {63'b0, busy}, 64'h1);
        @(posedge axis_aclk);
        #2;
        axis_aresetn = 1'b0;
        @(negedge axis_aclk);
        check_output("E_rst_ctrl", {59'b0, busy, sweep_irq, bus.cmp_ack, bus.m00_tvalid, bus.m01_tvalid}, 64'h0);
        check_output("E_rst_ready", {56'b0, bus.s_tready}, 64'h0);
        check_output("E_rst_res", {54'b0, res_valid, res_err, cur_pair}, 64'h0);
        check_output("E_rst_bank", {40'b0, res_bank}, 64'h0);
        ctrl_continuous = 1'b0;
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        repeat (2) @(negedge axis_aclk);
        served0 = served_cnt;
        apply_stimulus(4'b0011, 1'b0);
        repeat (4) @(negedge axis_aclk);
        check_output("E_restart_pair", {62'b0, cur_pair}, 64'h0);
        check_output("E_restart_busy", {63'b0, busy}, 64'h1);
        wait_idle("E_done_timeout", 12000, cyc);
        check_output("E_order", {56'b0, served_log[7:0]}, 64'h01);
        check_output("E_served", served_cnt - served0, 2);
        check_output("E_res_valid", {60'b0, res_valid}, 64'h3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
